// File: rtl/ov7670_capture.sv
// OV7670 capture front end: pairs camera bytes into RGB565 pixels and
// generates linear frame-buffer writes (VGA or 2:1 decimated QVGA).
module ov7670_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        capture_mode,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_enable,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_count
);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DONE} state_t;

  localparam logic [9:0] H_PX = 10'(H_ACTIVE);
  localparam logic [9:0] V_LN = 10'(V_ACTIVE);
  localparam logic [9:0] SAT  = 10'h3ff;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] HALF   = ADDR_W'(H_ACTIVE / 2);

  state_t state, state_nx;

  logic              vsync_q, vsync_qq;
  logic              href_q, href_qq;
  logic [7:0]        d_q;
  logic              qvga;
  logic              tog;
  logic              line_has;
  logic [7:0]        hi;
  logic [9:0]        px;
  logic [9:0]        ln;
  logic [ADDR_W-1:0] line_base;
  logic              err;

  logic       vs_rise, vs_fall, hr_fall;
  logic       pix_done, line_end, store;
  logic [9:0] px_off;

  assign vs_rise  = vsync_q & ~vsync_qq;
  assign vs_fall  = ~vsync_q & vsync_qq;
  assign hr_fall  = ~href_q & href_qq;
  assign pix_done = (state == ACTIVE) & href_q & tog;
  assign line_end = (state == ACTIVE) & hr_fall & line_has;
  assign store    = pix_done & (px < H_PX) & (ln < V_LN)
                  & (~qvga | (~px[0] & ~ln[0]));
  assign px_off   = qvga ? {1'b0, px[9:1]} : px;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      d_q      <= 8'd0;
    end else begin
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      href_q   <= href;
      href_qq  <= href_q;
      d_q      <= d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (enable && vsync_q) state_nx = SYNC;
      SYNC:   if (vs_fall) state_nx = ACTIVE;
      ACTIVE: if (vs_rise) state_nx = DONE;
      DONE:   state_nx = enable ? SYNC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    frame_done = (state == DONE);
    frame_err  = frame_done & (err | (ln != V_LN));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr     <= '0;
      wr_data     <= 16'd0;
      wr_enable   <= 1'b0;
      frame_count <= 8'd0;
      qvga        <= 1'b0;
      tog         <= 1'b0;
      line_has    <= 1'b0;
      hi          <= 8'd0;
      px          <= 10'd0;
      ln          <= 10'd0;
      line_base   <= '0;
      err         <= 1'b0;
    end else begin
      wr_enable <= 1'b0;
      if (state == DONE) frame_count <= frame_count + 8'd1;
      if (state == SYNC && vs_fall) begin
        qvga      <= (capture_mode == 2'b01);
        tog       <= 1'b0;
        line_has  <= 1'b0;
        px        <= 10'd0;
        ln        <= 10'd0;
        line_base <= '0;
        err       <= 1'b0;
      end else if (state == ACTIVE) begin
        if (!href_q) begin
          tog <= 1'b0;
        end else begin
          line_has <= 1'b1;
          if (!tog) begin
            hi  <= d_q;
            tog <= 1'b1;
          end else begin
            tog <= 1'b0;
            if (px != SAT) px <= px + 10'd1;
            if (store) begin
              wr_enable <= 1'b1;
              wr_addr   <= line_base + ADDR_W'(px_off);
              wr_data   <= {hi, d_q};
            end
          end
        end
        // Line end only fires with href_q low, so it never races a pixel
        if (line_end) begin
          px       <= 10'd0;
          line_has <= 1'b0;
          if (ln != SAT) ln <= ln + 10'd1;
          if (px != H_PX) err <= 1'b1;
          if (!qvga || ln[0])
            line_base <= line_base + (qvga ? HALF : STRIDE);
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized bench for ov7670_capture with a frame-level reference model
// and a scoreboard comparing every write and end-of-frame pulse.
module tb_ov7670_capture;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [1:0]    capture_mode;
  logic          vsync;
  logic          href;
  logic [7:0]    d;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_enable;
  logic          frame_done;
  logic          frame_err;
  logic [7:0]    frame_count;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .capture_mode(capture_mode), .vsync(vsync), .href(href), .d(d),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .frame_done(frame_done), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] q_addr[$];
  logic [15:0]   q_data[$];
  int            q_tag[$];
  bit            q_err[$];
  int            q_nw[$];
  int            q_cnt[$];

  bit cap;
  int fmode, ly, nw, exp_cnt;
  bit lerr;

  int wcnt = 0;
  bit cnt_pending = 0;
  int cnt_exp = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int tag_of(input int m, input int y, input int x);
    return (m << 20) | (y << 10) | x;
  endfunction

  // Model: where pixel (x,y) of the frame lands, if it is stored at all
  task automatic expect_px(input int x, input int y, input logic [7:0] b0,
                           input logic [7:0] b1);
    int a;
    if (!cap || x >= H || y >= V) return;
    if (fmode == 1) begin
      if ((x % 2) != 0 || (y % 2) != 0) return;
      a = (y / 2) * (H / 2) + x / 2;
    end else begin
      a = y * H + x;
    end
    q_addr.push_back(AW'(a));
    q_data.push_back({b0, b1});
    q_tag.push_back(tag_of(fmode, y, x));
    nw++;
  endtask

  task automatic flush_model();
    q_addr.delete(); q_data.delete(); q_tag.delete();
    q_err.delete(); q_nw.delete(); q_cnt.delete();
    wcnt = 0; cnt_pending = 0; exp_cnt = 0; nw = 0;
  endtask

  task automatic send_line(input int nbytes, input bit joint,
                           input int rst_at);
    int npx;
    logic [7:0] b0;
    npx = 0;
    b0 = 8'd0;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      href = 1'b1;
      d = 8'($urandom);
      if (i % 2 == 0) b0 = d;
      else begin
        expect_px(npx, ly, b0, d);
        npx++;
      end
      if (i == rst_at) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_wr_enable", 32'(wr_enable), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        flush_model();
        cap = 1'b0;
      end
    end
    if (nbytes > 0) begin
      if (npx != H) lerr = 1'b1;
      ly++;
    end
    if (!joint) begin
      @(negedge clk);
      href = 1'b0;
      d = 8'($urandom);
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic begin_frame(input int mode, input bit capf);
    @(negedge clk);
    capture_mode = 2'(mode);
    vsync = 1'b0;
    fmode = (mode == 1) ? 1 : 0;
    cap = capf;
    ly = 0;
    lerr = 1'b0;
    nw = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    href = 1'b0;
    vsync = 1'b1;
    if (cap) begin
      exp_cnt = (exp_cnt + 1) % 256;
      q_err.push_back(lerr || (ly != V));
      q_nw.push_back(nw);
      q_cnt.push_back(exp_cnt);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic plain_frame(input int mode, input bit capf);
    begin_frame(mode, capf);
    for (int y = 0; y < V; y++) send_line(2 * H, 1'b0, -1);
    end_frame();
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (cnt_pending) begin
        chk("frame_count", 32'(frame_count), 32'(cnt_exp));
        cnt_pending = 0;
      end
      if (wr_enable) begin
        if (q_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr got addr %0h want no write", wr_addr);
        end else begin
          logic [AW-1:0] ea;
          logic [15:0] ed;
          int tg;
          ea = q_addr.pop_front();
          ed = q_data.pop_front();
          tg = q_tag.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(ea));
          chk("wr_data", 32'(wr_data), 32'(ed));
          if (tg == tag_of(1, 2, 2)) chk("qvga_x2y2_addr", 32'(wr_addr), 9);
          if (tg == tag_of(0, 5, 0)) chk("line5_start", 32'(wr_addr), 80);
          if (tg == tag_of(0, V - 1, H - 1))
            chk("vga_last_addr", 32'(wr_addr), 127);
          wcnt++;
        end
      end
      if (frame_done) begin
        if (q_err.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got 1 want 0");
        end else begin
          chk("frame_err", 32'(frame_err), 32'(q_err.pop_front()));
          chk("writes_per_frame", 32'(wcnt), 32'(q_nw.pop_front()));
          chk("writes_before_done", 32'(q_addr.size()), 0);
          cnt_exp = q_cnt.pop_front();
          cnt_pending = 1;
        end
        wcnt = 0;
      end else if (frame_err) begin
        checks++;
        errors++;
        $display("FAIL err_without_done got 1 want 0");
      end
    end
  end

  initial begin
    int lim;
    reset_n = 1'b0;
    enable = 1'b0;
    capture_mode = 2'b00;
    vsync = 1'b1;
    href = 1'b0;
    d = 8'd0;
    cap = 1'b0;
    fmode = 0; ly = 0; nw = 0; exp_cnt = 0; lerr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("init_wr_addr", 32'(wr_addr), 0);
    chk("init_wr_enable", 32'(wr_enable), 0);
    chk("init_frame_done", 32'(frame_done), 0);
    chk("init_frame_count", 32'(frame_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    plain_frame(0, 1'b1);
    chk("fc_after_first", 32'(frame_count), 1);

    // QVGA with href falling in the same cycle vsync rises
    begin_frame(1, 1'b1);
    for (int y = 0; y < V; y++) send_line(2 * H, (y == V - 1), -1);
    end_frame();

    // Odd, long, short and very long lines; mode toggled mid-frame
    begin_frame(0, 1'b1);
    send_line(2 * H, 1'b0, -1);
    send_line(2 * H, 1'b0, -1);
    capture_mode = 2'b01;
    send_line(2 * H + 1, 1'b0, -1);
    send_line(2 * H + 8, 1'b0, -1);
    send_line(20, 1'b0, -1);
    send_line(2 * H, 1'b0, -1);
    send_line(2100, 1'b0, -1);
    send_line(2 * H, 1'b0, -1);
    end_frame();

    plain_frame(1, 1'b1);

    // Too many lines, reserved mode code
    begin_frame(2, 1'b1);
    for (int y = 0; y < V + 2; y++) send_line(2 * H, 1'b0, -1);
    end_frame();

    begin_frame(0, 1'b1);
    for (int y = 0; y < V - 2; y++) send_line(2 * H, 1'b0, -1);
    end_frame();

    // Enable dropped mid-frame: this frame completes, next is ignored
    begin_frame(0, 1'b1);
    for (int y = 0; y < V; y++) begin
      if (y == 3) enable = 1'b0;
      send_line(2 * H, 1'b0, -1);
    end
    end_frame();
    begin_frame(0, 1'b0);
    for (int y = 0; y < V; y++) send_line(2 * H, 1'b0, -1);
    enable = 1'b1;
    end_frame();

    // Reset mid-line; capture resumes only after a full vsync pulse
    begin_frame(0, 1'b1);
    send_line(2 * H, 1'b0, -1);
    send_line(2 * H, 1'b0, 9);
    @(negedge clk);
    reset_n = 1'b1;
    for (int y = 2; y < V; y++) send_line(2 * H, 1'b0, -1);
    end_frame();
    plain_frame(1, 1'b1);
    plain_frame($urandom_range(0, 1), 1'b1);

    lim = 0;
    while ((q_addr.size() != 0 || q_err.size() != 0) && lim < 100) begin
      @(negedge clk);
      lim++;
    end
    @(negedge clk);
    chk("drain_writes", 32'(q_addr.size()), 0);
    chk("drain_done", 32'(q_err.size()), 0);
    chk("final_count", 32'(frame_count), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side capture front end: takes the OV7670 parallel bus (PCLK domain), assembles byte pairs into RGB565 pixels, and generates linear frame-buffer write addresses, write strobes and an end-of-frame pulse. It sits directly upstream of the frame buffer controller and drives its write port (`wr_addr`, `wr_data`, `wr_enable`, `frame_done`) in the camera clock domain. It supports full VGA capture and 2:1 decimated QVGA capture.

## Interface
- `H_ACTIVE`, default 640: pixels per active line (VGA mode).
- `V_ACTIVE`, default 480: active lines per frame (VGA mode).
- `ADDR_W`, default 19: write address width.
- `clk` input, 1 bit: camera PCLK. Single clock for the block. All logic on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: arms capture. Level-sensitive.
- `capture_mode` input, 2 bits: 00 = VGA, 01 = QVGA decimate. 10/11 are treated as 00. Sampled only at frame start.
- `vsync` input, 1 bit: camera VSYNC; high during vertical blanking.
- `href` input, 1 bit: camera HREF; high during active line bytes.
- `d` input, 8 bits: camera data byte.
- `wr_addr` output, ADDR_W bits: pixel address.
- `wr_data` output, 16 bits: RGB565 pixel, first byte in [15:8].
- `wr_enable` output, 1 bit: one-cycle write strobe per stored pixel.
- `frame_done` output, 1 bit: one-cycle pulse at end of frame.
- `frame_err` output, 1 bit: valid with `frame_done`. High when the frame had a line count ≠ expected, or any line pixel count ≠ expected.
- `frame_count` output, 8 bits: completed frames; wraps 255→0.

## Operation
- Input stage:
  - `vsync`, `href` and `d` are registered once (`_q`).
  - Edges are detected on `_q` versus a second register.
- State machine:
  - **IDLE**: waits for `enable`=1 and `vsync_q`=1, then goes to SYNC.
  - **SYNC**: waits for `vsync_q` falling.
    - Latches the mode: 01 is QVGA; anything else is VGA.
    - Clears the line, pixel and address counters, then goes to ACTIVE.
  - **ACTIVE**: captures data.
    - On `vsync_q` rising it goes to DONE.
    - A `vsync_q` rising edge seen in IDLE or SYNC is not treated as end of frame.
  - **DONE**: lasts one cycle.
    - Drives `frame_done`=1 and `frame_err`, and increments `frame_count`.
    - Next state is SYNC if `enable`=1, otherwise IDLE.
- Deasserting `enable` during ACTIVE does not truncate the frame; it completes normally.
- Byte pairing:
  - A byte toggle clears while `href_q`=0.
  - The first byte with `href_q`=1 is latched as the high byte.
  - The second byte completes the pixel.
  - A line ending on an odd byte drops the half pixel.
- Per-line pixel counter (`px`, 10 bits):
  - Increments per completed pixel and saturates at 1023.
  - Pixels with `px` ≥ H_ACTIVE are not written.
- Line counter (`ln`):
  - Increments on `href_q` falling when that line contained ≥1 byte.
  - Lines with `ln` ≥ V_ACTIVE are not written.
- Address generation (no multiplier):
  - A `line_base` register is cleared at frame start.
  - VGA mode:
    - Every pixel is stored at `line_base`+`px`.
    - `line_base` += H_ACTIVE at each line end.
  - QVGA mode:
    - Only even `px` on even `ln` are stored, at `line_base`+`px`/2.
    - `line_base` += H_ACTIVE/2 after each odd line.
  - A short line still advances `line_base` by the full stride.
- `frame_err` is set when either of these holds:
  - final `ln` ≠ V_ACTIVE;
  - any counted line ended with `px` ≠ H_ACTIVE.

## Timing
- Reset values:
  - State IDLE.
  - `wr_addr`=0, `wr_data`=0, `wr_enable`=0.
  - `frame_done`=0, `frame_err`=0, `frame_count`=0.
  - All internal counters 0.
- Reset is asynchronous at any point, including mid-line. Capture resumes only at the next full IDLE→SYNC→ACTIVE sequence.
- Latency: the second byte of a pixel present on `d` at edge N produces `wr_enable`=1 with its `wr_addr`/`wr_data` after edge N+1 (2 cycles pin-to-strobe).
- `wr_addr`/`wr_data` hold their value between strobes.
- `frame_done` asserts 2 cycles after `vsync` rises on the pins.
- The last pixel write always precedes `frame_done`.
- `href` falling and `vsync` rising in the same cycle: the line end is processed first, and that line counts toward `ln` and `frame_err`.
- Maximum address in VGA mode is 307199 (0x4AFFF); it never exceeds this.

## Test plan
- **Reset:** drive `reset_n`=0 mid-line → all outputs 0 immediately. After release, no `wr_enable` until a `vsync` pulse and falling edge.
- **VGA frame:** drive 480 lines × 1280 bytes with a pixel ramp →
  - 307200 strobes with addresses 0..307199 in order;
  - `wr_data` = {byte0, byte1};
  - one `frame_done` with `frame_err`=0, and `frame_count`=1.
- **QVGA frame:** send the same stimulus with `capture_mode`=01 →
  - 76800 strobes with addresses 0..76799;
  - the pixel at (x=2, y=2) is written at address 321.
- **Long/short line:** send line 3 with 1300 bytes and line 4 with 1000 bytes →
  - no write at or beyond `px`=640 on line 3;
  - line 5 starts at address 3200;
  - `frame_err`=1.
- **Enable drop:** deassert `enable` at line 100 → the frame completes with 307200 writes, then the block stays in IDLE and the next frame produces no strobes.
- **Mode change mid-frame:** toggle `capture_mode` during ACTIVE → current frame addressing is unchanged; the new mode applies from the next frame.
